// File: rtl/axis_multichannel_averager.sv
// Multi-channel AXI-Stream averager: accumulates triggered frames of signed lanes into a dual-port BRAM.
// Optional macro AXIS_AVERAGER_SATURATE_EN: lane sums clamp and raise AVG_overflow; otherwise sums wrap.
module axis_multichannel_averager #(
  parameter int CHANNEL_COUNT   = 2,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int ACC_WIDTH       = 32,
  parameter int BRAM_ADDR_WIDTH = 14,
  parameter int FRAME_WIDTH     = 32,
  localparam int BRAM_DATA_WIDTH = CHANNEL_COUNT * ACC_WIDTH
) (
  input  logic                                    SYS_aclk,
  input  logic                                    SYS_aresetn,
  input  logic [CHANNEL_COUNT*SAMPLE_WIDTH-1:0]   S_AXIS_tdata,
  input  logic                                    S_AXIS_tvalid,
  output logic                                    S_AXIS_tready,
  input  logic                                    AVG_trigger,
  input  logic                                    AVG_user_reset,
  input  logic [BRAM_ADDR_WIDTH:0]                AVG_samples_count,
  input  logic [FRAME_WIDTH-1:0]                  AVG_frame_target,
  output logic [FRAME_WIDTH-1:0]                  AVG_frames,
  output logic                                    AVG_is_finished,
  output logic                                    AVG_overflow,
  output logic                                    BRAM_PORTA_clk,
  output logic                                    BRAM_PORTA_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]              BRAM_PORTA_addr,
  output logic [BRAM_DATA_WIDTH-1:0]              BRAM_PORTA_wrdata,
  output logic                                    BRAM_PORTA_we,
  input  logic [BRAM_DATA_WIDTH-1:0]              BRAM_PORTA_rddata,
  output logic                                    BRAM_PORTB_clk,
  output logic                                    BRAM_PORTB_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]              BRAM_PORTB_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]              BRAM_PORTB_rddata,
  output logic [BRAM_DATA_WIDTH-1:0]              BRAM_PORTB_wrdata,
  output logic                                    BRAM_PORTB_we
);

  localparam int CNT_W = BRAM_ADDR_WIDTH + 1;
  localparam logic [2:0] ST_CLEAR   = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_MEASURE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]                              state_r;
  logic [CNT_W-1:0]                        idx_r, clr_cnt_r, last_idx_s;
  logic                                    tready_r, finished_r, overflow_r;
  logic [FRAME_WIDTH-1:0]                  frames_r, frames_inc_s;
  logic [BRAM_ADDR_WIDTH-1:0]              porta_addr_r, portb_addr_r, s1_addr_r;
  logic [BRAM_DATA_WIDTH-1:0]              porta_wrdata_r, sum_data_s;
  logic                                    porta_we_r, s1_valid_r, accept_s, ovf_s;
  logic [CHANNEL_COUNT*SAMPLE_WIDTH-1:0]   s1_data_r;
  logic signed [ACC_WIDTH:0]               lane_sample_s, lane_acc_s;
  logic [ACC_WIDTH-1:0]                    lane_res_s;
`ifdef AXIS_AVERAGER_SATURATE_EN
  logic signed [ACC_WIDTH:0]               lane_sum_s;
`endif
  logic                                    unused_rddata_s;

  assign accept_s     = S_AXIS_tvalid && tready_r;
  assign last_idx_s   = AVG_samples_count - CNT_W'(1);
  assign frames_inc_s = frames_r + FRAME_WIDTH'(1);

  // Stage-2 lane adder: sign-extended sample plus the BRAM word returned for the stage-1 beat.
  always_comb begin
    sum_data_s    = '0;
    ovf_s         = 1'b0;
    lane_sample_s = '0;
    lane_acc_s    = '0;
    lane_res_s    = '0;
`ifdef AXIS_AVERAGER_SATURATE_EN
    lane_sum_s    = '0;
`endif
    for (int c = 0; c < CHANNEL_COUNT; c++) begin
      lane_sample_s = {{(ACC_WIDTH + 1 - SAMPLE_WIDTH){s1_data_r[c*SAMPLE_WIDTH + SAMPLE_WIDTH - 1]}},
                       s1_data_r[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]};
      lane_acc_s    = {BRAM_PORTB_rddata[c*ACC_WIDTH + ACC_WIDTH - 1],
                       BRAM_PORTB_rddata[c*ACC_WIDTH +: ACC_WIDTH]};
`ifdef AXIS_AVERAGER_SATURATE_EN
      lane_sum_s = lane_sample_s + lane_acc_s;
      if (lane_sum_s[ACC_WIDTH] != lane_sum_s[ACC_WIDTH-1]) begin
        ovf_s      = 1'b1;
        lane_res_s = lane_sum_s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                           : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        lane_res_s = lane_sum_s[ACC_WIDTH-1:0];
      end
`else
      lane_res_s = ACC_WIDTH'(lane_sample_s + lane_acc_s);
`endif
      sum_data_s[c*ACC_WIDTH +: ACC_WIDTH] = lane_res_s;
    end
  end

  // Control FSM, two-stage accumulate pipeline and all registered outputs.
  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state_r        <= ST_CLEAR;
      idx_r          <= '0;
      clr_cnt_r      <= '0;
      tready_r       <= 1'b0;
      finished_r     <= 1'b0;
      overflow_r     <= 1'b0;
      frames_r       <= '0;
      porta_addr_r   <= '0;
      portb_addr_r   <= '0;
      porta_wrdata_r <= '0;
      porta_we_r     <= 1'b0;
      s1_valid_r     <= 1'b0;
      s1_addr_r      <= '0;
      s1_data_r      <= '0;
    end else if (AVG_user_reset) begin
      state_r        <= ST_CLEAR;
      idx_r          <= '0;
      clr_cnt_r      <= '0;
      tready_r       <= 1'b0;
      finished_r     <= 1'b0;
      overflow_r     <= 1'b0;
      frames_r       <= '0;
      porta_addr_r   <= '0;
      portb_addr_r   <= '0;
      porta_wrdata_r <= '0;
      porta_we_r     <= 1'b0;
      s1_valid_r     <= 1'b0;
      s1_addr_r      <= '0;
      s1_data_r      <= '0;
    end else begin
      porta_we_r <= 1'b0;
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= S_AXIS_tdata;
        s1_addr_r <= idx_r[BRAM_ADDR_WIDTH-1:0];
      end
      if (s1_valid_r) begin
        porta_addr_r   <= s1_addr_r;
        porta_wrdata_r <= sum_data_s;
        porta_we_r     <= 1'b1;
        if (ovf_s) begin
          overflow_r <= 1'b1;
        end
      end
      case (state_r)
        ST_CLEAR: begin
          porta_addr_r   <= clr_cnt_r[BRAM_ADDR_WIDTH-1:0];
          porta_wrdata_r <= '0;
          porta_we_r     <= 1'b1;
          // Keep the read port one word ahead of the clear so the ports never meet.
          portb_addr_r   <= BRAM_ADDR_WIDTH'(clr_cnt_r + CNT_W'(1));
          clr_cnt_r      <= clr_cnt_r + CNT_W'(1);
          if (clr_cnt_r == last_idx_s) begin
            clr_cnt_r <= '0;
            if (AVG_frame_target == {FRAME_WIDTH{1'b0}}) begin
              state_r    <= ST_DONE;
              finished_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          if (AVG_trigger) begin
            state_r      <= ST_MEASURE;
            tready_r     <= 1'b1;
            idx_r        <= '0;
            portb_addr_r <= '0;
          end
        end
        ST_MEASURE: begin
          if (accept_s) begin
            idx_r        <= idx_r + CNT_W'(1);
            portb_addr_r <= BRAM_ADDR_WIDTH'(idx_r + CNT_W'(1));
            if (idx_r == last_idx_s) begin
              tready_r <= 1'b0;
              state_r  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!s1_valid_r && !porta_we_r) begin
            frames_r <= frames_inc_s;
            if (frames_inc_s == AVG_frame_target) begin
              state_r    <= ST_DONE;
              finished_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          finished_r <= 1'b1;
        end
        default: begin
          state_r <= ST_CLEAR;
        end
      endcase
    end
  end

  assign unused_rddata_s   = ^BRAM_PORTA_rddata;

  assign S_AXIS_tready     = tready_r;
  assign AVG_frames        = frames_r;
  assign AVG_is_finished   = finished_r;
  assign AVG_overflow      = overflow_r;
  assign BRAM_PORTA_clk    = SYS_aclk;
  assign BRAM_PORTA_rst    = ~SYS_aresetn;
  assign BRAM_PORTA_addr   = porta_addr_r;
  assign BRAM_PORTA_wrdata = porta_wrdata_r;
  assign BRAM_PORTA_we     = porta_we_r;
  assign BRAM_PORTB_clk    = SYS_aclk;
  assign BRAM_PORTB_rst    = ~SYS_aresetn;
  assign BRAM_PORTB_addr   = portb_addr_r;
  assign BRAM_PORTB_wrdata = '0;
  assign BRAM_PORTB_we     = 1'b0;

endmodule

// File: tb/tb_axis_multichannel_averager.sv
// Directed bench: 2-lane averager on a behavioural BRAM, plus a 1-lane 16-bit instance for wrap/saturation.
module tb_axis_multichannel_averager;

  logic        SYS_aclk = 1'b0;
  logic        SYS_aresetn;
  always #5 SYS_aclk = ~SYS_aclk;

  // Main instance: 2 lanes, 16-bit samples, 32-bit accumulators, 16-word BRAM
  logic [31:0] tdata;
  logic        tvalid, tready, trig, ures;
  logic [4:0]  count;
  logic [31:0] target, frames;
  logic        finished, ovf;
  logic        pa_clk, pa_rst, pa_we, pb_clk, pb_rst, pb_we;
  logic [3:0]  pa_addr, pb_addr;
  logic [63:0] pa_wr, pb_wr, pb_rd;
  logic [63:0] pa_rd = 64'd0;
  logic [63:0] mem0 [0:15];
  logic        preload;

  // Second instance: 1 lane, ACC_WIDTH == SAMPLE_WIDTH == 16
  logic [15:0] s_tdata;
  logic        s_tvalid, s_tready, s_trig;
  logic        s_ures = 1'b0;
  logic [4:0]  s_count;
  logic [31:0] s_target, s_frames;
  logic        s_finished, s_ovf;
  logic        s_pa_clk, s_pa_rst, s_pa_we, s_pb_clk, s_pb_rst, s_pb_we;
  logic [3:0]  s_pa_addr, s_pb_addr;
  logic [15:0] s_pa_wr, s_pb_wr, s_pb_rd;
  logic [15:0] s_pa_rd = 16'd0;
  logic [15:0] mem1 [0:15];

  axis_multichannel_averager #(
    .CHANNEL_COUNT(2), .SAMPLE_WIDTH(16), .ACC_WIDTH(32), .BRAM_ADDR_WIDTH(4), .FRAME_WIDTH(32)
  ) dut (
    .SYS_aclk(SYS_aclk), .SYS_aresetn(SYS_aresetn),
    .S_AXIS_tdata(tdata), .S_AXIS_tvalid(tvalid), .S_AXIS_tready(tready),
    .AVG_trigger(trig), .AVG_user_reset(ures),
    .AVG_samples_count(count), .AVG_frame_target(target),
    .AVG_frames(frames), .AVG_is_finished(finished), .AVG_overflow(ovf),
    .BRAM_PORTA_clk(pa_clk), .BRAM_PORTA_rst(pa_rst), .BRAM_PORTA_addr(pa_addr),
    .BRAM_PORTA_wrdata(pa_wr), .BRAM_PORTA_we(pa_we), .BRAM_PORTA_rddata(pa_rd),
    .BRAM_PORTB_clk(pb_clk), .BRAM_PORTB_rst(pb_rst), .BRAM_PORTB_addr(pb_addr),
    .BRAM_PORTB_rddata(pb_rd), .BRAM_PORTB_wrdata(pb_wr), .BRAM_PORTB_we(pb_we)
  );

  axis_multichannel_averager #(
    .CHANNEL_COUNT(1), .SAMPLE_WIDTH(16), .ACC_WIDTH(16), .BRAM_ADDR_WIDTH(4), .FRAME_WIDTH(32)
  ) dut_sat (
    .SYS_aclk(SYS_aclk), .SYS_aresetn(SYS_aresetn),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .AVG_trigger(s_trig), .AVG_user_reset(s_ures),
    .AVG_samples_count(s_count), .AVG_frame_target(s_target),
    .AVG_frames(s_frames), .AVG_is_finished(s_finished), .AVG_overflow(s_ovf),
    .BRAM_PORTA_clk(s_pa_clk), .BRAM_PORTA_rst(s_pa_rst), .BRAM_PORTA_addr(s_pa_addr),
    .BRAM_PORTA_wrdata(s_pa_wr), .BRAM_PORTA_we(s_pa_we), .BRAM_PORTA_rddata(s_pa_rd),
    .BRAM_PORTB_clk(s_pb_clk), .BRAM_PORTB_rst(s_pb_rst), .BRAM_PORTB_addr(s_pb_addr),
    .BRAM_PORTB_rddata(s_pb_rd), .BRAM_PORTB_wrdata(s_pb_wr), .BRAM_PORTB_we(s_pb_we)
  );

  // Behavioural BRAMs: write on port A, 1-cycle registered read on port B
  always @(posedge SYS_aclk) begin
    if (preload) begin
      for (int k = 0; k < 16; k++) mem0[k] <= {64{1'b1}};
    end else if (pa_we) begin
      mem0[pa_addr] <= pa_wr;
    end
    pb_rd <= mem0[pb_addr];
    if (s_pa_we) mem1[s_pa_addr] <= s_pa_wr;
    s_pb_rd <= mem1[s_pb_addr];
  end

  int wr_total, coll;
  int wcnt [0:15];
  always @(posedge SYS_aclk) begin
    if (pa_we) begin
      wr_total++;
      wcnt[pa_addr]++;
      if (pa_addr == pb_addr) coll++;
    end
    if (s_pa_we && s_pa_addr == s_pb_addr) coll++;
  end

  typedef struct {
    logic [15:0] l0;
    logic [15:0] l1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  vec_t tbl [0:7];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_sums();
    for (int k = 0; k < 8; k++) chk($sformatf("word%0d", k), mem0[k], {tbl[k].e1, tbl[k].e0});
  endtask

  // One triggered frame on the main instance; bub selects the 1,0,0,1 tvalid pattern
  task automatic run_frame(input bit bub);
    int i, cyc, n;
    logic [31:0] f0;
    f0 = frames;
    trig = 1'b1;
    @(negedge SYS_aclk);
    trig = 1'b0;
    chk("tready_after_trigger", tready, 1);
    i = 0;
    cyc = 0;
    while (i < 8 && cyc < 200) begin
      tvalid = bub ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      tdata  = {tbl[i].l1, tbl[i].l0};
      if (tvalid && tready) i++;
      cyc++;
      @(negedge SYS_aclk);
    end
    tvalid = 1'b0;
    chk("beats_accepted", i, 8);
    chk("tready_drop_after_last", tready, 0);
    n = 1;
    while (frames == f0 && n < 20) begin
      @(negedge SYS_aclk);
      n++;
    end
    chk("frames_inc_latency", n, 4);
    chk("frames_inc", frames, f0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bi, cyc, rise0, rise1, bad, first_addr, beats;
    bit prev_r, saw;
    SYS_aresetn = 1'b0;
    preload = 1'b1;
    count = 5'd8; target = 32'd2; trig = 1'b0; ures = 1'b0; tvalid = 1'b0; tdata = 32'd0;
    s_count = 5'd2; s_target = 32'd2; s_trig = 1'b0; s_tvalid = 1'b0; s_tdata = 16'd0;
    wr_total = 0; coll = 0;
    for (int k = 0; k < 16; k++) wcnt[k] = 0;
    for (int k = 0; k < 8; k++) begin
      tbl[k].l0 = 16'(k);
      tbl[k].l1 = 16'(-k);
      tbl[k].e0 = 32'(2 * k);
      tbl[k].e1 = 32'(-2 * k);
    end

    repeat (3) @(negedge SYS_aclk);
    chk("rst_tready", tready, 0);
    chk("rst_finished", finished, 0);
    chk("rst_frames", frames, 0);
    chk("rst_overflow", ovf, 0);
    chk("rst_pa_addr", pa_addr, 0);
    chk("rst_pb_addr", pb_addr, 0);
    chk("rst_pa_wrdata", pa_wr, 0);
    chk("rst_pa_we", pa_we, 0);
    chk("rst_pa_rst", pa_rst, 1);
    preload = 1'b0;
    wr_total = 0;
    @(negedge SYS_aclk);
    SYS_aresetn = 1'b1;
    repeat (12) @(negedge SYS_aclk);

    // Clear: exactly count words zeroed over the 0xFF.. preload
    chk("clear_writes", wr_total, 8);
    for (int k = 0; k < 8; k++) chk($sformatf("clear_word%0d", k), mem0[k], 64'd0);
    chk("clear_word8_untouched", mem0[8], {64{1'b1}});
    chk("idle_tready", tready, 0);
    chk("idle_frames", frames, 0);
    chk("pb_we_tied", pb_we, 0);

    // Accumulation: gap-free frame, then bubbly frame
    wr_total = 0;
    run_frame(1'b0);
    chk("frame1_writes", wr_total, 8);
    chk("frame1_not_finished", finished, 0);
    wr_total = 0;
    run_frame(1'b1);
    chk("bubble_writes", wr_total, 8);
    chk("acc_frames", frames, 2);
    chk("acc_finished", finished, 1);
    chk_sums();

    saw = 1'b0;
    trig = 1'b1;
    repeat (4) begin @(negedge SYS_aclk); saw = saw | tready; end
    trig = 1'b0;
    chk("done_ignores_trigger", saw, 0);

    // Back-to-back: trigger held high, tvalid always high
    ures = 1'b1; trig = 1'b1;
    @(negedge SYS_aclk);
    ures = 1'b0;
    tvalid = 1'b1;
    bi = 0; cyc = 0; prev_r = 1'b0; rise0 = -1; rise1 = -1;
    while (!finished && cyc < 200) begin
      @(negedge SYS_aclk);
      cyc++;
      if (tready && !prev_r) begin
        if (rise0 < 0) begin
          rise0 = cyc;
          for (int k = 0; k < 16; k++) wcnt[k] = 0;
        end else begin
          rise1 = cyc;
        end
      end
      prev_r = tready;
      tdata = {tbl[bi].l1, tbl[bi].l0};
      if (tready) bi = (bi + 1) % 8;
    end
    trig = 1'b0; tvalid = 1'b0;
    chk("b2b_finished", finished, 1);
    chk("b2b_frames", frames, 2);
    chk("b2b_gap_ge_12", (rise1 - rise0 >= 12) ? 1 : 0, 1);
    bad = 0;
    for (int k = 0; k < 8; k++) if (wcnt[k] != 2) bad++;
    chk("b2b_words_written_twice", bad, 0);
    chk_sums();

    // Abort at beat 3 of the second frame, with stale BRAM content
    ures = 1'b1;
    @(negedge SYS_aclk);
    ures = 1'b0;
    repeat (10) @(negedge SYS_aclk);
    run_frame(1'b0);
    preload = 1'b1;
    @(negedge SYS_aclk);
    preload = 1'b0;
    trig = 1'b1;
    @(negedge SYS_aclk);
    trig = 1'b0;
    tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tdata = {tbl[k].l1, tbl[k].l0};
      if (k == 3) ures = 1'b1;
      @(negedge SYS_aclk);
    end
    ures = 1'b0; tvalid = 1'b0;
    chk("abort_we_dropped", pa_we, 0);
    chk("abort_tready", tready, 0);
    chk("abort_frames", frames, 0);
    first_addr = -1;
    for (int k = 0; k < 20 && first_addr < 0; k++) begin
      @(negedge SYS_aclk);
      if (pa_we) first_addr = int'(pa_addr);
    end
    chk("abort_clear_first_addr", first_addr, 0);
    repeat (12) @(negedge SYS_aclk);
    bad = 0;
    for (int k = 0; k < 8; k++) if (mem0[k] != 64'd0) bad++;
    chk("abort_clear_nonzero_words", bad, 0);
    chk("abort_word8_untouched", mem0[8], {64{1'b1}});

    // Target 0: DONE straight after CLEAR, triggers ignored
    target = 32'd0;
    ures = 1'b1;
    @(negedge SYS_aclk);
    ures = 1'b0;
    repeat (7) @(negedge SYS_aclk);
    chk("t0_not_finished_in_clear", finished, 0);
    @(negedge SYS_aclk);
    chk("t0_finished_after_clear", finished, 1);
    saw = 1'b0;
    trig = 1'b1;
    repeat (5) begin @(negedge SYS_aclk); saw = saw | tready; end
    trig = 1'b0;
    chk("t0_trigger_ignored", saw, 0);
    chk("t0_frames", frames, 0);

    // Saturation / wrap on the 16-bit accumulator instance
    for (int f = 0; f < 2; f++) begin
      s_trig = 1'b1;
      @(negedge SYS_aclk);
      s_trig = 1'b0;
      s_tvalid = 1'b1;
      s_tdata = 16'h7000;
      beats = 0; cyc = 0;
      while (beats < 2 && cyc < 50) begin
        if (s_tready) beats++;
        cyc++;
        @(negedge SYS_aclk);
      end
      s_tvalid = 1'b0;
      cyc = 0;
      while (s_frames != 32'(f + 1) && cyc < 20) begin
        @(negedge SYS_aclk);
        cyc++;
      end
      chk($sformatf("sat_frame%0d_done", f), s_frames, f + 1);
    end
    chk("sat_finished", s_finished, 1);
`ifdef AXIS_AVERAGER_SATURATE_EN
    chk("sat_word0", mem1[0], 16'h7FFF);
    chk("sat_word1", mem1[1], 16'h7FFF);
    chk("sat_overflow", s_ovf, 1);
`else
    chk("wrap_word0", mem1[0], 16'hE000);
    chk("wrap_word1", mem1[1], 16'hE000);
    chk("wrap_overflow", s_ovf, 0);
`endif
    chk("main_overflow_zero", ovf, 0);
    chk("port_collisions", coll, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
